// File: rtl/counter_read_arbiter.sv
// Two-master read arbiter in front of a shared counter peripheral.
// One transaction is outstanding at a time. A requester is accepted in IDLE
// (its waitrequest drops combinationally in that cycle), then the slave read
// is issued in ISSUE, the fixed slave latency is counted out in WAIT, and the
// captured data is returned to the winner with a one-cycle valid in RESP.
// When both masters request together, round-robin on a 1-bit last grant.
//
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   m0_address/m0_read              master 0 read request (held until accepted)
//   m0_waitrequest                  master 0 stall, low only in its accept cycle
//   m0_readdata/m0_readdatavalid    master 0 registered data and valid pulse
//   m1_*                            same set for master 1
//   s_address/s_read                read address and strobe to the peripheral
//   s_readdata                      peripheral read data
module counter_read_arbiter #(
    parameter int unsigned ADDR_W       = 4,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset,

    input  logic [ADDR_W-1:0] m0_address,
    input  logic              m0_read,
    output logic              m0_waitrequest,
    output logic [DATA_W-1:0] m0_readdata,
    output logic              m0_readdatavalid,

    input  logic [ADDR_W-1:0] m1_address,
    input  logic              m1_read,
    output logic              m1_waitrequest,
    output logic [DATA_W-1:0] m1_readdata,
    output logic              m1_readdatavalid,

    output logic [ADDR_W-1:0] s_address,
    output logic              s_read,
    input  logic [DATA_W-1:0] s_readdata
);

    // Counter holds READ_LATENCY-1, at most 6.
    localparam int unsigned CNT_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              id_q, id_d;
    logic              last_grant_q, last_grant_d;
    logic [DATA_W-1:0] rdata0_q, rdata0_d;
    logic [DATA_W-1:0] rdata1_q, rdata1_d;
    logic              win_c;
    logic              grant0_c, grant1_c;

    // State register and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            addr_q       <= '0;
            id_q         <= 1'b0;
            last_grant_q <= 1'b1;
            rdata0_q     <= '0;
            rdata1_q     <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            addr_q       <= addr_d;
            id_q         <= id_d;
            last_grant_q <= last_grant_d;
            rdata0_q     <= rdata0_d;
            rdata1_q     <= rdata1_d;
        end
    end

    // Next-state, arbitration and capture logic.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        addr_d       = addr_q;
        id_d         = id_q;
        last_grant_d = last_grant_q;
        rdata0_d     = rdata0_q;
        rdata1_d     = rdata1_q;
        win_c        = 1'b0;
        grant0_c     = 1'b0;
        grant1_c     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (m0_read || m1_read) begin
                    // Tie goes to the master not granted last.
                    win_c    = (m0_read && m1_read) ? ~last_grant_q : m1_read;
                    grant0_c = ~win_c;
                    grant1_c = win_c;
                    id_d     = win_c;
                    addr_d   = win_c ? m1_address : m0_address;
                    state_d  = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                cnt_d   = CNT_W'(READ_LATENCY - 1);
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    if (id_q) rdata1_d = s_readdata;
                    else      rdata0_d = s_readdata;
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_RESP: begin
                last_grant_d = id_q;
                state_d      = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Handshake outputs are forced inactive while reset is asserted.
    assign m0_waitrequest   = ~(grant0_c & ~reset);
    assign m1_waitrequest   = ~(grant1_c & ~reset);
    assign s_read           = (state_q == ST_ISSUE) & ~reset;
    assign s_address        = addr_q;
    assign m0_readdatavalid = (state_q == ST_RESP) & ~id_q & ~reset;
    assign m1_readdatavalid = (state_q == ST_RESP) &  id_q & ~reset;
    assign m0_readdata      = rdata0_q;
    assign m1_readdata      = rdata1_q;

endmodule

// File: tb/tb_counter_read_arbiter.sv
// Directed bench for counter_read_arbiter: one instance with READ_LATENCY=1
// and one with READ_LATENCY=3, each with a counter slave that returns
// 32'hA000_0000 | address exactly READ_LATENCY cycles after s_read.
module tb_counter_read_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Instance A: READ_LATENCY = 1
    logic        a_reset;
    logic [3:0]  a_m0_address, a_m1_address, a_s_address;
    logic        a_m0_read, a_m1_read, a_s_read;
    logic        a_m0_wr, a_m1_wr, a_m0_rdv, a_m1_rdv;
    logic [31:0] a_m0_rd, a_m1_rd, a_s_readdata;

    // Instance B: READ_LATENCY = 3
    logic        b_reset;
    logic [3:0]  b_m0_address, b_m1_address, b_s_address;
    logic        b_m0_read, b_m1_read, b_s_read;
    logic        b_m0_wr, b_m1_wr, b_m0_rdv, b_m1_rdv;
    logic [31:0] b_m0_rd, b_m1_rd, b_s_readdata;

    counter_read_arbiter #(.ADDR_W(4), .DATA_W(32), .READ_LATENCY(1)) u_a (
        .clk(clk), .reset(a_reset),
        .m0_address(a_m0_address), .m0_read(a_m0_read), .m0_waitrequest(a_m0_wr),
        .m0_readdata(a_m0_rd), .m0_readdatavalid(a_m0_rdv),
        .m1_address(a_m1_address), .m1_read(a_m1_read), .m1_waitrequest(a_m1_wr),
        .m1_readdata(a_m1_rd), .m1_readdatavalid(a_m1_rdv),
        .s_address(a_s_address), .s_read(a_s_read), .s_readdata(a_s_readdata)
    );

    counter_read_arbiter #(.ADDR_W(4), .DATA_W(32), .READ_LATENCY(3)) u_b (
        .clk(clk), .reset(b_reset),
        .m0_address(b_m0_address), .m0_read(b_m0_read), .m0_waitrequest(b_m0_wr),
        .m0_readdata(b_m0_rd), .m0_readdatavalid(b_m0_rdv),
        .m1_address(b_m1_address), .m1_read(b_m1_read), .m1_waitrequest(b_m1_wr),
        .m1_readdata(b_m1_rd), .m1_readdatavalid(b_m1_rdv),
        .s_address(b_s_address), .s_read(b_s_read), .s_readdata(b_s_readdata)
    );

    // Slave models: valid data only READ_LATENCY cycles after s_read, junk otherwise.
    logic [31:0] a_pipe;
    logic [31:0] b_pipe0, b_pipe1, b_pipe2;
    always_ff @(posedge clk) begin
        a_pipe  <= a_s_read ? (32'hA000_0000 | 32'(a_s_address)) : 32'hDEAD_BEEF;
        b_pipe0 <= b_s_read ? (32'hA000_0000 | 32'(b_s_address)) : 32'hDEAD_BEEF;
        b_pipe1 <= b_pipe0;
        b_pipe2 <= b_pipe1;
    end
    assign a_s_readdata = a_pipe;
    assign b_s_readdata = b_pipe2;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int n;

    initial begin
        a_reset = 1'b1; a_m0_read = 1'b1; a_m1_read = 1'b1;
        a_m0_address = 4'h4; a_m1_address = 4'h1;
        b_reset = 1'b1; b_m0_read = 1'b0; b_m1_read = 1'b0;
        b_m0_address = 4'h0; b_m1_address = 4'h0;

        // Reset held two cycles with both reads high.
        tick(); tick();
        check("rst_s_read", 32'(a_s_read), 32'd0);
        check("rst_wr0",    32'(a_m0_wr),  32'd1);
        check("rst_wr1",    32'(a_m1_wr),  32'd1);
        check("rst_rdv0",   32'(a_m0_rdv), 32'd0);
        check("rst_rdv1",   32'(a_m1_rdv), 32'd0);
        check("rst_rd0",    a_m0_rd,       32'd0);
        check("rst_rd1",    a_m1_rd,       32'd0);

        // Tie out of reset: m0 first, then m1.
        a_reset = 1'b0; #1;
        check("tie_acc_wr0", 32'(a_m0_wr), 32'd0);
        check("tie_acc_wr1", 32'(a_m1_wr), 32'd1);
        tick(); a_m0_read = 1'b0; #1;
        check("tie_issue_s_read", 32'(a_s_read),    32'd1);
        check("tie_issue_addr",   32'(a_s_address), 32'h4);
        check("tie_issue_wr1",    32'(a_m1_wr),     32'd1);
        tick();
        check("tie_wait_s_read",  32'(a_s_read),    32'd0);
        check("tie_wait_rdv0",    32'(a_m0_rdv),    32'd0);
        tick();
        check("tie_resp_rdv0",    32'(a_m0_rdv),    32'd1);
        check("tie_resp_rd0",     a_m0_rd,          32'hA000_0004);
        check("tie_resp_rdv1",    32'(a_m1_rdv),    32'd0);
        check("tie_resp_wr1",     32'(a_m1_wr),     32'd1);
        tick();
        check("tie_m1_acc_wr1",   32'(a_m1_wr),     32'd0);
        tick(); a_m1_read = 1'b0; #1;
        check("tie_m1_issue_addr", 32'(a_s_address), 32'h1);
        tick(); tick();
        check("tie_m1_rdv1",      32'(a_m1_rdv),    32'd1);
        check("tie_m1_rd1",       a_m1_rd,          32'hA000_0001);
        check("tie_m1_rd0_kept",  a_m0_rd,          32'hA000_0004);
        check("tie_m1_rdv0",      32'(a_m0_rdv),    32'd0);

        // Single master m0 reading address 0.
        tick();
        a_m0_address = 4'h0; a_m0_read = 1'b1; #1;
        check("single_wr0", 32'(a_m0_wr), 32'd0);
        check("single_wr1", 32'(a_m1_wr), 32'd1);
        tick(); a_m0_read = 1'b0; #1;
        check("single_s_read", 32'(a_s_read),    32'd1);
        check("single_addr",   32'(a_s_address), 32'h0);
        tick(); tick();
        check("single_rdv0",   32'(a_m0_rdv),    32'd1);
        check("single_rd0",    a_m0_rd,          32'hA000_0000);
        check("single_rd1",    a_m1_rd,          32'hA000_0001);

        // Fairness: reset restores last_grant so m0 wins the first tie.
        tick();
        a_reset = 1'b1; tick();
        a_reset = 1'b0;
        a_m0_address = 4'h2; a_m1_address = 4'h3;
        a_m0_read = 1'b1; a_m1_read = 1'b1; #1;
        for (int k = 0; k < 6; k++) begin
            check($sformatf("fair%0d_wr0", k), 32'(a_m0_wr), (k % 2 == 0) ? 32'd0 : 32'd1);
            check($sformatf("fair%0d_wr1", k), 32'(a_m1_wr), (k % 2 == 0) ? 32'd1 : 32'd0);
            tick();
            check($sformatf("fair%0d_addr", k), 32'(a_s_address), (k % 2 == 0) ? 32'h2 : 32'h3);
            tick(); tick();
            if (k % 2 == 0) begin
                check($sformatf("fair%0d_rdv", k), 32'(a_m0_rdv), 32'd1);
                check($sformatf("fair%0d_rd", k),  a_m0_rd,       32'hA000_0002);
            end else begin
                check($sformatf("fair%0d_rdv", k), 32'(a_m1_rdv), 32'd1);
                check($sformatf("fair%0d_rd", k),  a_m1_rd,       32'hA000_0003);
            end
            tick();
        end
        a_m0_read = 1'b0; a_m1_read = 1'b0; #1;

        // Reset during WAIT aborts the transaction.
        a_m0_address = 4'h5; a_m0_read = 1'b1; #1;
        check("abort_acc_wr0", 32'(a_m0_wr), 32'd0);
        tick(); a_m0_read = 1'b0; #1;
        check("abort_issue", 32'(a_s_read), 32'd1);
        tick();
        a_reset = 1'b1; #1;
        check("abort_rst_s_read", 32'(a_s_read), 32'd0);
        check("abort_rst_wr0",    32'(a_m0_wr),  32'd1);
        tick();
        a_reset = 1'b0; #1;
        check("abort_rdv0_a", 32'(a_m0_rdv), 32'd0);
        tick();
        check("abort_rdv0_b",   32'(a_m0_rdv), 32'd0);
        check("abort_s_read",   32'(a_s_read), 32'd0);
        check("abort_rd0",      a_m0_rd,       32'd0);
        a_m1_address = 4'h6; a_m1_read = 1'b1; #1;
        check("post_abort_acc_wr1", 32'(a_m1_wr), 32'd0);
        tick(); a_m1_read = 1'b0; #1;
        tick(); tick();
        check("post_abort_rdv1", 32'(a_m1_rdv), 32'd1);
        check("post_abort_rd1",  a_m1_rd,       32'hA000_0006);

        // READ_LATENCY=3: valid five cycles after accept.
        b_reset = 1'b0;
        tick();
        b_m1_address = 4'h2; b_m1_read = 1'b1; #1;
        check("lat3_acc_wr1", 32'(b_m1_wr), 32'd0);
        tick(); b_m1_read = 1'b0; #1;
        n = 1;
        while (!b_m1_rdv && n < 20) begin
            tick();
            n++;
        end
        check("lat3_cycles", 32'(n), 32'd5);
        check("lat3_rd1",    b_m1_rd, 32'hA000_0002);
        check("lat3_rdv0",   32'(b_m0_rdv), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/counter_read_arbiter.md
COUNTER_READ_ARBITER -- requirements
Module: counter_read_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 4, meaning the slave word-address width.
REQ-002 The block SHALL have parameter DATA_W, default 32, meaning the read data width.
REQ-003 The block SHALL have parameter READ_LATENCY, default 1, legal 1..7, meaning the number of cycles from the s_read cycle to the s_readdata sample cycle.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 m0_address  input  ADDR_W  master 0 read address.
REQ-007 m0_read  input  1  master 0 read request; held until accepted.
REQ-008 m0_waitrequest  output  1  master 0 stall; low only in m0's accept cycle.
REQ-009 m0_readdata  output  DATA_W  master 0 returned data, registered.
REQ-010 m0_readdatavalid  output  1  one-cycle pulse qualifying m0_readdata.
REQ-011 m1_address, m1_read, m1_waitrequest, m1_readdata, m1_readdatavalid SHALL mirror REQ-006..REQ-010 for master 1.
REQ-012 s_address  output  ADDR_W  address to the shared counter peripheral.
REQ-013 s_read  output  1  read strobe to the counter peripheral.
REQ-014 s_readdata  input  DATA_W  counter peripheral read data.

Function
REQ-015 The FSM SHALL have states IDLE, ISSUE, WAIT and RESP, and SHALL allow one outstanding transaction at a time.
REQ-016 IDLE with no mX_read asserted SHALL remain in IDLE.
REQ-017 IDLE with any mX_read SHALL select a winner, drive the winner's waitrequest low combinationally that cycle, latch the winner's address and ID, and go to ISSUE.
REQ-018 Arbitration SHALL give a single requester the grant; with both requesting, the grant SHALL go to the master not granted last (round-robin, 1-bit last_grant).
REQ-019 ISSUE SHALL drive s_read=1 and s_address=latched address for exactly one cycle, load the latency counter with READ_LATENCY-1, and go to WAIT.
REQ-020 WAIT SHALL decrement the counter each cycle; on the cycle the counter equals 0, s_readdata SHALL be registered into the winner's readdata register and the FSM SHALL go to RESP.
REQ-021 RESP SHALL assert the winner's readdatavalid for exactly one cycle, update last_grant to the winner's ID, and return to IDLE.
REQ-022 Latency SHALL be READ_LATENCY+2 cycles from the accept cycle to the readdatavalid cycle, and throughput SHALL be one transaction per READ_LATENCY+3 cycles.
REQ-023 mX_waitrequest SHALL be 1 in every cycle other than that master's accept cycle, including when mX_read=0.
REQ-024 s_read SHALL be 0 outside ISSUE, and s_address SHALL hold the last latched address.
REQ-025 The losing master's request SHALL remain pending with waitrequest=1 and be served in the next IDLE cycle without starvation.
REQ-026 The non-winner's readdata register SHALL be unchanged and its readdatavalid SHALL stay 0.
REQ-027 A master that deasserts read before acceptance SHALL simply not be granted, with no side effect.

Reset
REQ-028 When reset=1 at a clock edge, the FSM SHALL go to IDLE, clear the latency counter, set last_grant=1 (master 0 wins the first tie), set s_address=0, and clear both readdata registers to 0.
REQ-029 During reset, s_read=0, both readdatavalid=0, and both waitrequest=1, with no grant.
REQ-030 Reset asserted mid-transaction SHALL abort the transaction, generate no readdatavalid, and issue no further s_read.

Verification (slave model returns 32'hA000_0000 | address after READ_LATENCY cycles)
REQ-031 Reset check: hold reset=1 for 2 cycles with both reads high -> s_read=0, both waitrequest=1, both readdatavalid=0, and both readdata=0.
REQ-032 Single master: m0 reads address 4'h0 with READ_LATENCY=1 -> m0_waitrequest low in cycle 0, s_read high in cycle 1 with s_address=0, and m0_readdatavalid high in cycle 3 with m0_readdata=32'hA000_0000.
REQ-033 Tie: m0 reads 4'h4 and m1 reads 4'h1 together from reset -> m0 served first (data 32'hA000_0004), then m1 accepted in the next IDLE cycle (data 32'hA000_0001).
REQ-034 Fairness: both masters request continuously for 6 transactions -> grants alternate m0, m1, m0, m1, m0, m1, and each transaction is 4 cycles apart with READ_LATENCY=1.
REQ-035 Latency parameter: READ_LATENCY=3, m1 reads 4'h2 -> readdatavalid arrives 5 cycles after accept with data 32'hA000_0002.
REQ-036 Mid-operation reset: assert reset for 1 cycle during WAIT -> no readdatavalid, FSM in IDLE, and a subsequent m1 read completes normally.
